// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_ADR = 2'b01,
    STAT_INS = 2'b10,
    STAT_HLT = 2'b11
  } stat_e;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int unsigned DEF_ADDR_W    = 64;
  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_MEM_WORDS = 1024;
  localparam int unsigned DEF_MAX_WAIT  = 4;

  // One outstanding response: who owns it, whether it was a write, and
  // whether the address was out of range.
  typedef struct packed {
    logic    valid;
    req_id_e owner;
    logic    we;
    logic    err;
  } rsp_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between fetch and memory-stage requests.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate winners on conflict).
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             f_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] wait_cnt,
  input  req_id_e          rr_ptr,
  output logic             grant_f,
  output logic             grant_d
);

  // Pick at most one winner; a starved fetch always wins a conflict.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (f_req && d_req) begin
      if (wait_cnt == CNT_W'(MAX_WAIT)) begin
        grant_f = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      end else if (rr_ptr == REQ_F) begin
        grant_f = 1'b1;
`endif
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_f = f_req;
      grant_d = d_req;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter between fetch and memory stages.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on conflict).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
  parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         f_req,
  input  logic [ADDR_W-1:0]            f_addr,
  output logic                         f_gnt,
  output logic                         f_rvalid,
  output logic [DATA_W-1:0]            f_rdata,
  output logic                         f_err,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [DATA_W-1:0]            d_rdata,
  output logic [1:0]                   d_stat,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

  logic             sel_f;
  logic             sel_d;
  logic             f_ok;
  logic             d_ok;
  logic [CNT_W-1:0] wait_cnt;
  req_id_e          rr_ptr;
  rsp_t             rsp;

  assign f_ok = (f_addr < ADDR_W'(MEM_WORDS));
  assign d_ok = (d_addr < ADDR_W'(MEM_WORDS));

  mem_arb_select #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_select (
    .f_req   (f_req),
    .d_req   (d_req),
    .wait_cnt(wait_cnt),
    .rr_ptr  (rr_ptr),
    .grant_f (sel_f),
    .grant_d (sel_d)
  );

  // Grants are combinational but forced low while reset is held.
  assign f_gnt = sel_f & ~reset;
  assign d_gnt = sel_d & ~reset;

  // Drive the array port for the granted in-range access only.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt && d_ok) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr[MEM_AW-1:0];
      mem_wdata = d_wdata;
    end else if (f_gnt && f_ok) begin
      mem_en    = 1'b1;
      mem_addr  = f_addr[MEM_AW-1:0];
      mem_wdata = d_wdata;
    end
  end

  // Count consecutive fetch denials, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (f_req && !f_gnt) begin
      if (wait_cnt != CNT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // rr_ptr names the requester favoured on the next conflict; after reset
  // that is data, so "last winner = fetch" is the equivalent reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= REQ_D;
    end else if (f_gnt && d_req) begin
      rr_ptr <= REQ_D;
    end else if (d_gnt && f_req) begin
      rr_ptr <= REQ_F;
    end
  end

  // Record the granted access so exactly one response follows next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp <= '0;
    end else begin
      rsp.valid <= f_gnt | d_gnt;
      rsp.owner <= d_gnt ? REQ_D : REQ_F;
      rsp.we    <= d_gnt & d_we;
      rsp.err   <= d_gnt ? ~d_ok : ~f_ok;
    end
  end

  // Present the response; read data passes through from the array.
  always_comb begin
    f_rvalid = rsp.valid && (rsp.owner == REQ_F);
    d_rvalid = rsp.valid && (rsp.owner == REQ_D);
    f_err    = f_rvalid && rsp.err;
    f_rdata  = (f_rvalid && !rsp.err) ? mem_rdata : '0;
    d_rdata  = (d_rvalid && !rsp.err && !rsp.we) ? mem_rdata : '0;
    d_stat   = (d_rvalid && rsp.err) ? STAT_ADR : STAT_AOK;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand sequences
// for contention and reset, then constrained-random traffic against a model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MAX_WAIT  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, f_gnt, f_rvalid, f_err;
  logic [63:0]       f_addr, f_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [63:0]       d_addr, d_wdata, d_rdata;
  logic [1:0]        d_stat;
  logic              mem_en, mem_we;
  logic [9:0]        mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata = '0;
  logic [63:0]       mem_array [MEM_WORDS];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stat(d_stat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port array: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  function automatic logic [63:0] init_word(int unsigned i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h101);
  endfunction

  typedef struct {
    bit fr; logic [63:0] fa; bit dr; bit dwe; logic [63:0] da; logic [63:0] dwd;
  } stim_t;

  typedef struct {
    bit fg, dg, me, mw, frv, fer, drv;
    logic [9:0] ma; logic [63:0] mwd, frd, drd; logic [1:0] dst;
  } obs_t;

  typedef struct {
    stim_t s;
    bit fg, dg, me, frv, fer, drv;
    logic [63:0] frd, drd; logic [1:0] dst;
  } vec_t;

  // Reference model: consecutive-denial count, conflict preference,
  // one pending response and a shadow copy of memory contents.
  int          m_wait;
  bit          m_d_next;
  bit          p_valid, p_f, p_we, p_err;
  logic [63:0] p_rdata;
  logic [63:0] shadow [MEM_WORDS];
  bit          m_fg, m_dg;

  task automatic model_reset();
    m_wait = 0; m_d_next = 1'b1; p_valid = 1'b0; p_f = 1'b0;
    p_we = 1'b0; p_err = 1'b0; p_rdata = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, check against
  // the model when asked, then advance the model past the rising edge.
  task automatic step(input stim_t s, input bit use_model, output obs_t o);
    bit f_in, d_in, fw, dw;
    @(negedge clk);
    f_req = s.fr; f_addr = s.fa; d_req = s.dr; d_we = s.dwe;
    d_addr = s.da; d_wdata = s.dwd;
    #1;
    o.fg = f_gnt; o.dg = d_gnt; o.me = mem_en; o.mw = mem_we; o.ma = mem_addr;
    o.mwd = mem_wdata; o.frv = f_rvalid; o.fer = f_err; o.frd = f_rdata;
    o.drv = d_rvalid; o.drd = d_rdata; o.dst = d_stat;

    f_in = s.fa < 64'(MEM_WORDS);
    d_in = s.da < 64'(MEM_WORDS);
    fw = 1'b0; dw = 1'b0;
    if (s.fr && s.dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (m_d_next) dw = 1'b1; else fw = 1'b1;
      m_d_next = fw;
`else
      if (m_wait >= int'(MAX_WAIT)) fw = 1'b1; else dw = 1'b1;
`endif
    end else begin
      fw = s.fr; dw = s.dr;
    end
    m_fg = fw; m_dg = dw;

    if (use_model) begin
      chk("f_gnt", 64'(o.fg), 64'(fw));
      chk("d_gnt", 64'(o.dg), 64'(dw));
      chk("mem_en", 64'(o.me), 64'((fw && f_in) || (dw && d_in)));
      chk("mem_we", 64'(o.mw), 64'(dw && d_in && s.dwe));
      if (dw && d_in) begin
        chk("mem_addr", 64'(o.ma), s.da % 64'(MEM_WORDS));
        if (s.dwe) chk("mem_wdata", o.mwd, s.dwd);
      end else if (fw && f_in) begin
        chk("mem_addr", 64'(o.ma), s.fa % 64'(MEM_WORDS));
      end
      chk("f_rvalid", 64'(o.frv), 64'(p_valid && p_f));
      chk("f_err", 64'(o.fer), 64'(p_valid && p_f && p_err));
      chk("f_rdata", o.frd, (p_valid && p_f && !p_err) ? p_rdata : 64'd0);
      chk("d_rvalid", 64'(o.drv), 64'(p_valid && !p_f));
      chk("d_stat", 64'(o.dst), (p_valid && !p_f && p_err) ? 64'd1 : 64'd0);
      chk("d_rdata", o.drd, (p_valid && !p_f && !p_err && !p_we) ? p_rdata : 64'd0);
    end

    p_valid = fw || dw;
    p_f = fw;
    p_we = dw && s.dwe;
    p_err = fw ? !f_in : !d_in;
    p_rdata = '0;
    if (fw && f_in) p_rdata = shadow[s.fa % 64'(MEM_WORDS)];
    if (dw && d_in) begin
      if (s.dwe) shadow[s.da % 64'(MEM_WORDS)] = s.dwd;
      else       p_rdata = shadow[s.da % 64'(MEM_WORDS)];
    end
    if (s.fr && !fw) m_wait = (m_wait < int'(MAX_WAIT)) ? m_wait + 1 : m_wait;
    else             m_wait = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_gnt"}, 64'(f_gnt), 64'd0);
    chk({tag, "_d_gnt"}, 64'(d_gnt), 64'd0);
    chk({tag, "_f_rvalid"}, 64'(f_rvalid), 64'd0);
    chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
    chk({tag, "_f_err"}, 64'(f_err), 64'd0);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_rdata"}, f_rdata | d_rdata, 64'd0);
    chk({tag, "_d_stat"}, 64'(d_stat), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(bit fr, logic [63:0] fa, bit dr, bit dwe,
                              logic [63:0] da, logic [63:0] dwd,
                              bit fg, bit dg, bit me, bit frv, bit fer,
                              logic [63:0] frd, bit drv, logic [1:0] dst,
                              logic [63:0] drd);
    vec_t v;
    v.s.fr = fr; v.s.fa = fa; v.s.dr = dr; v.s.dwe = dwe; v.s.da = da; v.s.dwd = dwd;
    v.fg = fg; v.dg = dg; v.me = me; v.frv = frv; v.fer = fer; v.frd = frd;
    v.drv = drv; v.dst = dst; v.drd = drd;
    return v;
  endfunction

  initial begin
    vec_t  tbl [13];
    obs_t  o;
    stim_t s;
    stim_t idle;
    bit    f_pend, d_pend;

    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      mem_array[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    idle = '{fr: 0, fa: '0, dr: 0, dwe: 0, da: '0, dwd: '0};
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Directed vectors: RAW through memory, out-of-range write/read, fetch
    // alone, fetch error, and a first conflict resolved for data.
    tbl[0]  = mk(0, 0, 1, 1, 5, 64'hAB,              0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    tbl[1]  = mk(0, 0, 1, 0, 5, 0,                   0, 1, 1, 0, 0, 0, 1, 2'b00, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 1, 2'b00, 64'hAB);
    tbl[3]  = mk(0, 0, 1, 1, 1024, 64'h55,           0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0,                   0, 1, 1, 0, 0, 0, 1, 2'b01, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 1, 2'b00, init_word(0));
    tbl[6]  = mk(1, 64'h10, 0, 0, 0, 0,              1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 0, init_word(16), 0, 2'b00, 0);
    tbl[8]  = mk(1, 64'hFFFF_0000_0000_0010, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 1, 0, 0, 2'b00, 0);
    tbl[10] = mk(1, 3, 1, 0, 7, 0,                   0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    tbl[11] = mk(1, 3, 0, 0, 0, 0,                   1, 0, 1, 0, 0, 0, 1, 2'b00, init_word(7));
    tbl[12] = mk(0, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 0, init_word(3), 0, 2'b00, 0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].s, 1'b0, o);
      chk($sformatf("row%0d_f_gnt", i), 64'(o.fg), 64'(tbl[i].fg));
      chk($sformatf("row%0d_d_gnt", i), 64'(o.dg), 64'(tbl[i].dg));
      chk($sformatf("row%0d_mem_en", i), 64'(o.me), 64'(tbl[i].me));
      chk($sformatf("row%0d_f_rvalid", i), 64'(o.frv), 64'(tbl[i].frv));
      chk($sformatf("row%0d_f_err", i), 64'(o.fer), 64'(tbl[i].fer));
      chk($sformatf("row%0d_f_rdata", i), o.frd, tbl[i].frd);
      chk($sformatf("row%0d_d_rvalid", i), 64'(o.drv), 64'(tbl[i].drv));
      chk($sformatf("row%0d_d_stat", i), 64'(o.dst), 64'(tbl[i].dst));
      chk($sformatf("row%0d_d_rdata", i), o.drd, tbl[i].drd);
    end

    // Both requesters held high from a clean reset.
    do_reset();
    s = '{fr: 1, fa: 64'h3, dr: 1, dwe: 0, da: 64'h4, dwd: '0};
    for (int i = 0; i < 12; i++) begin
      step(s, 1'b1, o);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("contend%0d_d_gnt", i), 64'(o.dg), 64'((i % 2) == 0));
`else
      chk($sformatf("contend%0d_d_gnt", i), 64'(o.dg), 64'((i % 5) != 4));
`endif
    end
    step(idle, 1'b1, o);

    // Reset while a fetch response is on the outputs.
    s = '{fr: 1, fa: 64'h20, dr: 0, dwe: 0, da: '0, dwd: '0};
    step(s, 1'b1, o);
    @(negedge clk);
    #1;
    chk("pre_reset_f_rvalid", 64'(f_rvalid), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    f_req = 1'b0;
    reset = 1'b0;
    model_reset();
    step(idle, 1'b1, o);
    chk("post_reset_f_rvalid", 64'(o.frv), 64'd0);
    chk("post_reset_d_rvalid", 64'(o.drv), 64'd0);

    // Random traffic; a denied requester holds its request stable.
    f_pend = 1'b0; d_pend = 1'b0;
    s = idle;
    for (int i = 0; i < 400; i++) begin
      if (!f_pend) begin
        s.fr = ($urandom_range(0, 3) != 0);
        s.fa = ($urandom_range(0, 11) == 0) ? (64'd1024 + 64'($urandom_range(0, 3)))
                                             : 64'($urandom_range(0, 15));
      end
      if (!d_pend) begin
        s.dr = $urandom_range(0, 1) == 1;
        s.dwe = $urandom_range(0, 1) == 1;
        s.da = ($urandom_range(0, 11) == 0) ? {32'($urandom) | 32'h1, 32'($urandom)}
                                             : 64'($urandom_range(0, 15));
        s.dwd = {32'($urandom), 32'($urandom)};
      end
      step(s, 1'b1, o);
      f_pend = s.fr && !m_fg;
      d_pend = s.dr && !m_dg;
    end
    step(idle, 1'b1, o);
    step(idle, 1'b1, o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported 1024-word data memory between the fetch stage (instruction reads) and the memory stage (rmmovq/mrmovq/pushq/popq/call/ret reads and writes). Grants one access per cycle, drives the memory array's port, returns read data one cycle after grant, and flags out-of-range addresses with the ADR status code. Sits between the fetch and memory stages and the memory array, replacing each stage's private array access.

## Interface
- ADDR_W, 64, requester address width (word address)
- DATA_W, 64, data word width
- MEM_WORDS, 1024, valid words; address >= MEM_WORDS is an error
- MAX_WAIT, 4, consecutive fetch denials before fetch is forced through

- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch response valid
- f_rdata  out  DATA_W  fetch read data
- f_err  out  1  fetch address error (with f_rvalid)
- d_req  in  1  memory-stage request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  memory-stage address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  memory-stage request accepted this cycle
- d_rvalid  out  1  memory-stage response valid (reads and writes)
- d_rdata  out  DATA_W  read data; 0 for writes
- d_stat  out  2  00 AOK, 01 ADR; valid with d_rvalid
- mem_en  out  1  array access strobe
- mem_we  out  1  array write enable
- mem_addr  out  $clog2(MEM_WORDS)  array word address
- mem_wdata  out  DATA_W  array write data
- mem_rdata  in  DATA_W  array read data, valid the cycle after a read strobe

## Operation
- Requester holds req/addr/we/wdata stable until gnt; gnt is combinational in the accepting cycle.
- At most one grant per cycle. Default priority: data over fetch.
- Starvation counter (0..MAX_WAIT): increments when f_req is high and denied; clears on f_gnt or when f_req is low. When counter == MAX_WAIT and both request, fetch wins.
- Granted in-range access: mem_en=1, mem_we=d_we (fetch: 0), mem_addr=addr[low bits], mem_wdata=d_wdata.
- Granted out-of-range access (addr >= MEM_WORDS, full ADDR_W compare): mem_en=0; response carries err/ADR, rdata 0. Writes are never performed.
- Response register records owner, read/write, and error; drives exactly one rvalid pulse per grant.
- Non-granted requester's outputs: gnt=0, no response.

## Timing
- Reset values: all gnt/rvalid/err/mem_en/mem_we 0, rdata 0, d_stat 00, mem_addr/mem_wdata 0, counter 0, round-robin pointer = data.
- Latency: grant in cycle N, rvalid in cycle N+1 (reads, writes, errors alike).
- Fully pipelined: a new grant in N+1 while the response for N is presented.
- Write at N followed by read of same address at N+1 returns the new data.
- Reset mid-operation: pending response discarded; no rvalid after reset deasserts.
- Both req with counter < MAX_WAIT: d_gnt=1, f_gnt=0, counter+1.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on conflict, grant alternates using a last-winner register (winner recorded on every conflict grant); starvation counter still present but never reaches MAX_WAIT under round robin.
- Undefined: fixed data-over-fetch priority with MAX_WAIT starvation override as above.

## Structure
- Shared package mem_arb_pkg: stat codes (STAT_AOK 2'b00, STAT_ADR 2'b01, STAT_INS 2'b10, STAT_HLT 2'b11), requester id type (REQ_F, REQ_D), default parameter constants.
- One sub-module: mem_arb_select — combinational winner selection from f_req, d_req, counter, last-winner, and the macro.

## Test plan
- Reset asserted mid-read: all outputs 0 immediately; no rvalid after release.
- d_req write addr 5 data 0xAB at N, d_req read addr 5 at N+1 -> d_rvalid N+1 (write ack, rdata 0), d_rvalid N+2 with d_rdata 0xAB, d_stat 00.
- f_req and d_req held high continuously, MAX_WAIT=4, macro undefined -> d_gnt four cycles, f_gnt on fifth, counter back to 0, pattern repeats.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN -> grants alternate D,F,D,F starting with D.
- d_req write addr 1024 -> mem_en 0, next cycle d_rvalid with d_stat 01; subsequent read of addr 0 unchanged.
- f_req addr 0x10 alone -> f_gnt same cycle, f_rvalid next cycle with array word 0x10, f_err 0.
